// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline-side hazard inputs, stall/flush/forward
// controls and the performance counters.
interface hazard_ctrl_unit_if #(
  parameter int unsigned ADW  = 5,
  parameter int unsigned CNTW = 32
);
  logic [ADW-1:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic            rs1_usedD, rs2_usedD;
  logic            regwriteE, resultsrcE, regwriteM, regwriteW;
  logic            PCSrcE, clr_cnt;
  logic            stallF, stallD, flushD, flushE;
  logic [1:0]      fwdAE, fwdBE;
  logic [CNTW-1:0] stall_cyc, flush_evt;

  // Pipeline side: drives hazard info, consumes controls
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, rs1_usedD, rs2_usedD,
           regwriteE, resultsrcE, regwriteM, regwriteW, PCSrcE, clr_cnt,
    input  stallF, stallD, flushD, flushE, fwdAE, fwdBE, stall_cyc, flush_evt
  );

  // Hazard unit side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, rs1_usedD, rs2_usedD,
           regwriteE, resultsrcE, regwriteM, regwriteW, PCSrcE, clr_cnt,
    output stallF, stallD, flushD, flushE, fwdAE, fwdBE, stall_cyc, flush_evt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage rv32i pipeline. Generates
// stall/flush controls for load-use (multi-cycle D-cache) and, in stall-only
// mode, all RAW hazards; EX forwarding selects; saturating perf counters.
module hazard_ctrl_unit #(
  parameter int unsigned ADW      = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned CNTW     = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_ctrl_unit_if.slave hz
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LSTALL = 1'b1;

  // First LSTALL cycle is the second stall cycle, hence LOAD_LAT-2
  localparam logic [1:0] CntInit = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;
  localparam bit         FwdOn   = (FWD_EN != 0);
  localparam bit         MultiLd = (LOAD_LAT > 1);
  localparam logic [ADW-1:0] RegZero = '0;

  logic [0:0]      stateQ, stateD;
  logic [1:0]      cntQ, cntD;
  logic [CNTW-1:0] stallCycQ, flushEvtQ;

  logic luHit, rawHit, src1Live, src2Live;
  logic stallReq, stallOut;
  logic [1:0] fwdA, fwdB;

  // Hazard detection; x0 never participates
  always_comb begin
    src1Live = hz.rs1_usedD & (hz.Rs1D != RegZero);
    src2Live = hz.rs2_usedD & (hz.Rs2D != RegZero);
    luHit    = hz.resultsrcE & hz.regwriteE & (hz.RdE != RegZero) &
               ((src1Live & (hz.Rs1D == hz.RdE)) | (src2Live & (hz.Rs2D == hz.RdE)));
    rawHit   = 1'b0;
    if (!FwdOn) begin
      // Write-through regfile: W never conflicts
      rawHit = (src1Live & ((hz.regwriteE & (hz.Rs1D == hz.RdE)) |
                            (hz.regwriteM & (hz.Rs1D == hz.RdM)))) |
               (src2Live & ((hz.regwriteE & (hz.Rs2D == hz.RdE)) |
                            (hz.regwriteM & (hz.Rs2D == hz.RdM))));
    end
  end

  // Forwarding selects, M has priority over W
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (FwdOn && !rst) begin
      if (hz.regwriteM && hz.RdM != RegZero && hz.RdM == hz.Rs1E) begin
        fwdA = 2'b10;
      end else if (hz.regwriteW && hz.RdW != RegZero && hz.RdW == hz.Rs1E) begin
        fwdA = 2'b01;
      end
      if (hz.regwriteM && hz.RdM != RegZero && hz.RdM == hz.Rs2E) begin
        fwdB = 2'b10;
      end else if (hz.regwriteW && hz.RdW != RegZero && hz.RdW == hz.Rs2E) begin
        fwdB = 2'b01;
      end
    end
  end

  // Stall/flush outputs; a taken branch overrides every stall
  always_comb begin
    stallReq  = (stateQ == LSTALL) | ((stateQ == IDLE) & luHit) | rawHit;
    stallOut  = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    if (!rst) begin
      if (hz.PCSrcE) begin
        hz.flushD = 1'b1;
        hz.flushE = 1'b1;
      end else begin
        stallOut  = stallReq;
        hz.flushE = stallReq;
      end
    end
  end

  assign hz.stallF    = stallOut;
  assign hz.stallD    = stallOut;
  assign hz.fwdAE     = fwdA;
  assign hz.fwdBE     = fwdB;
  assign hz.stall_cyc = stallCycQ;
  assign hz.flush_evt = flushEvtQ;

  // Load-use stall sequencing
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    if (hz.PCSrcE) begin
      stateD = IDLE;
      cntD   = 2'd0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (luHit && MultiLd) begin
            stateD = LSTALL;
            cntD   = CntInit;
          end
        end
        LSTALL: begin
          if (cntQ == 2'd0) begin
            stateD = IDLE;
          end else begin
            cntD = cntQ - 2'd1;
          end
        end
        default: begin
          stateD = IDLE;
          cntD   = 2'd0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      cntQ   <= 2'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Saturating perf counters; clear beats increment
  always_ff @(posedge clk) begin
    if (rst || hz.clr_cnt) begin
      stallCycQ <= '0;
      flushEvtQ <= '0;
    end else begin
      if (stallOut && stallCycQ != '1) begin
        stallCycQ <= stallCycQ + CNTW'(1);
      end
      if (hz.PCSrcE && flushEvtQ != '1) begin
        flushEvtQ <= flushEvtQ + CNTW'(1);
      end
    end
  end

endmodule
